vga_layer_compositor: RTL and testbench

Parametrised pixel compositor for the VGA game top level: merges NUM_LAYERS per-pixel layer hits (character, obstacles, score, map, scene) by fixed priority into registered RGB, blanks outside the display area, and owns the MENU/PLAY/DEAD game-mode state machine. Mode changes are deferred to frame boundaries so no frame tears. Sits between the layer generators / hvsync_generator and the VGA pins.

---
 rtl/vga_layer_compositor_if.sv | 28 ++
 rtl/vga_layer_compositor.sv | 146 ++++++++++++++
 tb/tb_vga_layer_compositor.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_layer_compositor_if.sv
// Signal bundle between the layer generators / sync logic and the compositor.
// The master side feeds pixels and game requests; the slave side returns VGA colour and game mode.
interface vga_layer_compositor_if #(
   parameter int NUM_LAYERS = 6,
   parameter int COLOR_W    = 1
);
   logic [NUM_LAYERS-1:0]           layer_valid;
   logic [NUM_LAYERS*3*COLOR_W-1:0] layer_rgb;
   logic                            in_display;
   logic                            frame_start;
   logic                            start;
   logic                            dead;
   logic [COLOR_W-1:0]              vga_R;
   logic [COLOR_W-1:0]              vga_G;
   logic [COLOR_W-1:0]              vga_B;
   logic [1:0]                      mode;
   logic                            blink;

   modport master (
      output layer_valid, layer_rgb, in_display, frame_start, start, dead,
      input  vga_R, vga_G, vga_B, mode, blink
   );

   modport slave (
      input  layer_valid, layer_rgb, in_display, frame_start, start, dead,
      output vga_R, vga_G, vga_B, mode, blink
   );
endinterface

// File: rtl/vga_layer_compositor.sv
// Fixed-priority layer compositor with display blanking and a MENU/PLAY/DEAD mode FSM.
// Mode changes land only on frame_start so a frame is never drawn with two different masks.
module vga_layer_compositor #(
   parameter int                    NUM_LAYERS  = 6,
   parameter int                    COLOR_W     = 1,
   parameter int                    DEAD_FRAMES = 120,
   parameter int                    BLINK_LOG2  = 3,
   parameter logic [NUM_LAYERS-1:0] MENU_MASK   = NUM_LAYERS'(6'b111100),
   parameter logic [NUM_LAYERS-1:0] PLAY_MASK   = NUM_LAYERS'(6'b111111),
   parameter logic [NUM_LAYERS-1:0] FLASH_MASK  = NUM_LAYERS'(6'b000001)
) (
   input logic                   clk,
   input logic                   reset,
   vga_layer_compositor_if.slave bus
);
   localparam int PIX_W   = 3 * COLOR_W;
   localparam int CNT_RAW = $clog2(DEAD_FRAMES + 1);
   localparam int CNT_W   = (CNT_RAW > BLINK_LOG2 + 1) ? CNT_RAW : BLINK_LOG2 + 1;
   localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(DEAD_FRAMES - 1);

   typedef enum logic [1:0] {
      MODE_MENU = 2'b00,
      MODE_PLAY = 2'b01,
      MODE_DEAD = 2'b10,
      MODE_BAD  = 2'b11
   } modeT;

   typedef enum logic [1:0] {
      PEND_NONE = 2'b00,
      PEND_PLAY = 2'b01,
      PEND_DEAD = 2'b10,
      PEND_MENU = 2'b11
   } pendT;

   modeT             r_mode;
   modeT             w_modeNext;
   pendT             r_pend;
   pendT             w_pendNext;
   pendT             w_req;
   pendT             w_eff;
   logic [CNT_W-1:0] r_deadCount;
   logic [CNT_W-1:0] w_cntNext;
   logic             w_blink;
   logic [NUM_LAYERS-1:0] w_mask;

   logic [NUM_LAYERS-1:0]       r_s1Valid;
   logic [NUM_LAYERS*PIX_W-1:0] r_s1Rgb;
   logic                        r_s1Disp;
   logic [PIX_W-1:0]            w_winRgb;
   logic [PIX_W-1:0]            r_pixel;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_mode      <= MODE_MENU;
         r_pend      <= PEND_NONE;
         r_deadCount <= '0;
      end else begin
         r_mode      <= w_modeNext;
         r_pend      <= w_pendNext;
         r_deadCount <= w_cntNext;
      end
   end

   // A request seen on the frame_start cycle itself overrides whatever was pending.
   always_comb begin
      w_modeNext = r_mode;
      w_pendNext = r_pend;
      w_cntNext  = r_deadCount;
      w_req      = PEND_NONE;
      case (r_mode)
         MODE_MENU: if (bus.start) w_req = PEND_PLAY;
         MODE_PLAY: if (bus.dead)  w_req = PEND_DEAD;
         MODE_DEAD: if (bus.start) w_req = PEND_PLAY;
         default:   w_req = PEND_NONE;
      endcase
      w_eff = (w_req != PEND_NONE) ? w_req : r_pend;

      if (r_mode == MODE_BAD) begin
         w_modeNext = MODE_MENU;
         w_pendNext = PEND_NONE;
         w_cntNext  = '0;
      end else if (bus.frame_start) begin
         w_pendNext = PEND_NONE;
         if (r_mode == MODE_DEAD) begin
            if (w_eff == PEND_PLAY) begin
               w_modeNext = MODE_PLAY;
               w_cntNext  = '0;
            end else if (w_eff == PEND_MENU || r_deadCount == LAST_FRAME) begin
               w_modeNext = MODE_MENU;
               w_cntNext  = '0;
            end else begin
               w_cntNext = r_deadCount + 1'b1;
            end
         end else begin
            case (w_eff)
               PEND_PLAY: w_modeNext = MODE_PLAY;
               PEND_DEAD: w_modeNext = MODE_DEAD;
               PEND_MENU: w_modeNext = MODE_MENU;
               default:   w_modeNext = r_mode;
            endcase
            w_cntNext = '0;
         end
      end else if (w_req != PEND_NONE) begin
         w_pendNext = w_req;
      end
   end

   assign w_blink = (r_mode == MODE_DEAD) && r_deadCount[BLINK_LOG2];

   always_comb begin
      w_mask = MENU_MASK;
      case (r_mode)
         MODE_PLAY: w_mask = PLAY_MASK;
         MODE_DEAD: w_mask = PLAY_MASK & ~(w_blink ? FLASH_MASK : {NUM_LAYERS{1'b0}});
         default:   w_mask = MENU_MASK;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_s1Valid <= '0;
         r_s1Rgb   <= '0;
         r_s1Disp  <= 1'b0;
         r_pixel   <= '0;
      end else begin
         r_s1Valid <= bus.layer_valid & w_mask;
         r_s1Rgb   <= bus.layer_rgb;
         r_s1Disp  <= bus.in_display;
         r_pixel   <= r_s1Disp ? w_winRgb : '0;
      end
   end

   // Scan from the lowest priority upward so the lowest index hit is written last.
   always_comb begin
      w_winRgb = '0;
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
         if (r_s1Valid[i]) w_winRgb = r_s1Rgb[i*PIX_W +: PIX_W];
      end
   end

   assign bus.vga_R = r_pixel[PIX_W-1 -: COLOR_W];
   assign bus.vga_G = r_pixel[2*COLOR_W-1 -: COLOR_W];
   assign bus.vga_B = r_pixel[COLOR_W-1:0];
   assign bus.mode  = r_mode;
   assign bus.blink = w_blink;
endmodule

// File: tb/tb_vga_layer_compositor.sv
// Randomized bench for vga_layer_compositor with an in-bench game/pixel model,
// per-cycle comparison and directed checks that pin the model to literal values.
module tb_vga_layer_compositor;
   localparam int NL = 6;
   localparam int CW = 1;
   localparam int DF = 120;
   localparam int BL = 3;
   localparam logic [5:0] MENU_M  = 6'b111100;
   localparam logic [5:0] PLAY_M  = 6'b111111;
   localparam logic [5:0] FLASH_M = 6'b000101;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   vga_layer_compositor_if #(.NUM_LAYERS(NL), .COLOR_W(CW)) bus ();

   vga_layer_compositor #(
      .NUM_LAYERS(NL), .COLOR_W(CW), .DEAD_FRAMES(DF), .BLINK_LOG2(BL),
      .MENU_MASK(MENU_M), .PLAY_MASK(PLAY_M), .FLASH_MASK(FLASH_M)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Model state: mode 0/1/2, pending request (-1 none), frame_starts seen since entering DEAD
   int         mMode   = 0;
   int         mPend   = -1;
   int         mFrames = 0;
   logic [2:0] mPipe   = 3'b000;
   logic [2:0] mVga    = 3'b000;

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [2:0] pixelOf(input logic [5:0] v, input logic [17:0] rgb,
                                          input logic disp, input logic [5:0] mask);
      if (!disp) return 3'b000;
      for (int i = 0; i < NL; i++) begin
         if (v[i] && mask[i]) return rgb[i*3 +: 3];
      end
      return 3'b000;
   endfunction

   function automatic logic modelBlink();
      return (mMode == 2) && (((mFrames >> BL) & 1) == 1);
   endfunction

   // Game rules: requests collect between frames, and everything resolves at a frame_start.
   always @(posedge clk) begin
      logic [5:0] mask;
      int req;
      int eff;
      if (mMode == 0)      mask = MENU_M;
      else if (mMode == 1) mask = PLAY_M;
      else                 mask = PLAY_M & ~(modelBlink() ? FLASH_M : 6'b000000);
      if (!reset) begin
         mMode = 0; mPend = -1; mFrames = 0; mPipe = 3'b000; mVga = 3'b000;
      end else begin
         mVga  = mPipe;
         mPipe = pixelOf(bus.layer_valid, bus.layer_rgb, bus.in_display, mask);
         req = -1;
         if ((mMode == 0 || mMode == 2) && bus.start) req = 1;
         if (mMode == 1 && bus.dead) req = 2;
         if (bus.frame_start) begin
            eff = (req >= 0) ? req : mPend;
            mPend = -1;
            if (mMode == 2) begin
               if (eff == 1) begin
                  mMode = 1; mFrames = 0;
               end else if (mFrames + 1 == DF) begin
                  mMode = 0; mFrames = 0;
               end else begin
                  mFrames++;
               end
            end else if (eff >= 0) begin
               mMode = eff; mFrames = 0;
            end
         end else if (req >= 0) begin
            mPend = req;
         end
      end
   end

   always @(negedge clk) begin
      checkOutput("cyc_mode", 8'(bus.mode), 8'(mMode));
      checkOutput("cyc_blink", 8'(bus.blink), 8'(modelBlink()));
      checkOutput("cyc_vga", 8'({bus.vga_R, bus.vga_G, bus.vga_B}), 8'(mVga));
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic applyStimulus();
      bus.layer_valid = 6'($urandom);
      bus.layer_rgb   = 18'($urandom);
      bus.in_display  = ($urandom_range(0, 3) != 0);
   endtask

   task automatic setPriorityPixel();
      logic [17:0] rgb;
      rgb = 18'($urandom);
      rgb[8:6]  = 3'b100;
      rgb[11:9] = 3'b010;
      bus.layer_valid = 6'b001100;
      bus.layer_rgb   = rgb;
      bus.in_display  = 1'b1;
   endtask

   task automatic runFrames(input int n);
      repeat (n) begin
         repeat (3) begin
            applyStimulus();
            tick(1);
         end
         applyStimulus();
         bus.frame_start = 1'b1;
         tick(1);
         bus.frame_start = 1'b0;
      end
   endtask

   initial begin
      bus.layer_valid = '0; bus.layer_rgb = '0; bus.in_display = 1'b0;
      bus.frame_start = 1'b0; bus.start = 1'b0; bus.dead = 1'b0;
      reset = 1'b0;
      tick(3);
      checkOutput("rst_mode", 8'(bus.mode), 8'h00);
      checkOutput("rst_blink", 8'(bus.blink), 8'h00);
      checkOutput("rst_vga", 8'({bus.vga_R, bus.vga_G, bus.vga_B}), 8'h00);
      reset = 1'b1;

      applyStimulus();
      tick(3);
      bus.start = 1'b1; tick(1); bus.start = 1'b0;
      tick(4);
      checkOutput("defer_hold", 8'(bus.mode), 8'h00);
      bus.frame_start = 1'b1; tick(1); bus.frame_start = 1'b0;
      checkOutput("defer_play", 8'(bus.mode), 8'h01);

      setPriorityPixel();
      tick(2);
      checkOutput("prio_win", 8'({bus.vga_R, bus.vga_G, bus.vga_B}), 8'h04);
      bus.layer_valid = 6'b000000;
      tick(2);
      checkOutput("prio_none", 8'({bus.vga_R, bus.vga_G, bus.vga_B}), 8'h00);
      bus.layer_valid = 6'b111111; bus.layer_rgb = '1; bus.in_display = 1'b0;
      tick(2);
      checkOutput("blank_off", 8'({bus.vga_R, bus.vga_G, bus.vga_B}), 8'h00);
      bus.in_display = 1'b1;
      tick(2);
      checkOutput("blank_on", 8'({bus.vga_R, bus.vga_G, bus.vga_B}), 8'h07);
      for (int i = 0; i < 8; i++) begin
         bus.in_display = i[0];
         tick(1);
      end

      bus.dead = 1'b1; bus.start = 1'b1; tick(1);
      bus.dead = 1'b0; bus.start = 1'b0;
      tick(2);
      checkOutput("dead_defer", 8'(bus.mode), 8'h01);
      bus.frame_start = 1'b1; tick(1); bus.frame_start = 1'b0;
      checkOutput("dead_enter", 8'(bus.mode), 8'h02);
      checkOutput("dead_blink0", 8'(bus.blink), 8'h00);
      runFrames(8);
      checkOutput("blink_on", 8'(bus.blink), 8'h01);
      setPriorityPixel();
      tick(2);
      checkOutput("flash_hide", 8'({bus.vga_R, bus.vga_G, bus.vga_B}), 8'h02);
      runFrames(8);
      checkOutput("blink_off", 8'(bus.blink), 8'h00);
      setPriorityPixel();
      tick(2);
      checkOutput("flash_show", 8'({bus.vga_R, bus.vga_G, bus.vga_B}), 8'h04);
      runFrames(103);
      checkOutput("dead_119", 8'(bus.mode), 8'h02);
      runFrames(1);
      checkOutput("dead_timeout", 8'(bus.mode), 8'h00);
      checkOutput("timeout_blink", 8'(bus.blink), 8'h00);

      bus.start = 1'b1; bus.frame_start = 1'b1; tick(1);
      bus.start = 1'b0; bus.frame_start = 1'b0;
      checkOutput("coincident_start", 8'(bus.mode), 8'h01);
      bus.dead = 1'b1; bus.frame_start = 1'b1; tick(1);
      bus.dead = 1'b0; bus.frame_start = 1'b0;
      checkOutput("coincident_dead", 8'(bus.mode), 8'h02);
      runFrames(50);
      bus.start = 1'b1; tick(1); bus.start = 1'b0;
      tick(2);
      checkOutput("restart_hold", 8'(bus.mode), 8'h02);
      bus.frame_start = 1'b1; tick(1); bus.frame_start = 1'b0;
      checkOutput("restart_play", 8'(bus.mode), 8'h01);
      checkOutput("restart_blink", 8'(bus.blink), 8'h00);

      bus.dead = 1'b1; bus.frame_start = 1'b1; tick(1);
      bus.dead = 1'b0; bus.frame_start = 1'b0;
      runFrames(10);
      bus.start = 1'b1; tick(1);
      bus.layer_valid = 6'b111111; bus.layer_rgb = '1; bus.in_display = 1'b1;
      tick(1);
      reset = 1'b0; tick(1);
      bus.start = 1'b0; reset = 1'b1;
      checkOutput("rst_dead_mode", 8'(bus.mode), 8'h00);
      checkOutput("rst_dead_blink", 8'(bus.blink), 8'h00);
      checkOutput("rst_dead_vga", 8'({bus.vga_R, bus.vga_G, bus.vga_B}), 8'h00);
      tick(2);
      bus.frame_start = 1'b1; tick(1); bus.frame_start = 1'b0;
      checkOutput("rst_pend_clear", 8'(bus.mode), 8'h00);

      for (int c = 0; c < 4000; c++) begin
         applyStimulus();
         bus.start       = ((c % 1000) < 200) && ($urandom_range(0, 15) == 0);
         bus.dead        = ($urandom_range(0, 11) == 0);
         bus.frame_start = ($urandom_range(0, 5) == 0);
         reset           = ($urandom_range(0, 999) != 0);
         tick(1);
      end
      reset = 1'b1; bus.start = 1'b0; bus.dead = 1'b0; bus.frame_start = 1'b0;
      tick(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
